pe_accum_buffer: RTL and testbench
==================================

# pe_accum_buffer

Per-PE output accumulator for the sparse-CNN processing element. It receives coordinate-tagged partial products from the crossbar lanes and sums them into an on-chip buffer indexed by (output-channel offset k, row y, column x). On command from the PE controller it drains the buffer one output row per cycle to the post-processing unit (max-pooling and compression), clearing each row as it goes.

## Interface
Parameters:
- NUM_LANES, 4: crossbar output lanes delivered per cycle.
- KC, 2: output-channel offsets held (Kc); KW = clog2(KC).
- MAX_OUT, 8: maximum output width and height; CW = clog2(MAX_OUT).
- DW, 16: signed data width.

Ports (clock and reset first):
- clk, in, 1: single clock; all logic is on its rising edge.
- rst, in, 1: synchronous, active-high reset.
- conv_size_output_boundary, in, CW: last valid output row/column index of the current layer (output size − 1).
- drain_en, in, 1: level request to drain the buffer (PE controller state 3).
- xbar_valid, in, NUM_LANES: per-lane product valid.
- xbar_k, in, NUM_LANES×KW: per-lane channel offset.
- xbar_x, in, NUM_LANES×CW: per-lane output column.
- xbar_y, in, NUM_LANES×CW: per-lane output row.
- xbar_data, in, NUM_LANES×DW signed: per-lane product.
- ppu_valid, out, 1: drained row valid.
- ppu_last, out, 1: final row of the drain.
- ppu_k, out, KW: channel offset of the drained row.
- ppu_row, out, CW: row index of the drained row.
- ppu_data, out, MAX_OUT×DW signed: row values, index 0 = column 0.

## Operation
- Storage: KC×MAX_OUT×MAX_OUT signed DW-bit entries.
- States: ACCUM, DRAIN, DONE.
- ACCUM:
  - Each valid lane whose x and y are ≤ boundary and whose k < KC adds xbar_data to entry [k][y][x].
  - Lanes that fail any of these range checks are dropped silently.
  - Lanes that hit the same entry in the same cycle are all summed together with the stored value: entry ← entry + Σ matching lanes.
  - Arithmetic is two's-complement, truncated to DW bits (wraps, no saturation).
- ACCUM → DRAIN when drain_en = 1. Lane inputs in that same cycle are still accumulated.
- DRAIN:
  - A counter walks k = 0..KC−1 (outer loop) and y = 0..boundary (inner loop), one row per cycle.
  - Each cycle, output the row [k][y]; columns > boundary read as 0.
  - The emitted row is cleared to 0 in the same cycle.
  - On the final row (k = KC−1, y = boundary), set ppu_last and go to DONE.
  - Lane inputs are ignored while in DRAIN.
- DONE: lane inputs are ignored. Return to ACCUM when drain_en = 0. Holding drain_en high does not start a second drain.
- boundary is sampled on entry to DRAIN and held constant for the whole drain.
- drain_en dropping during DRAIN does not abort the drain; it runs to completion.

## Timing
- Reset: all entries 0; state ACCUM; ppu_valid = 0, ppu_last = 0, ppu_k = 0, ppu_row = 0, ppu_data = 0.
- Reset asserted mid-drain aborts the drain and clears the buffer.
- Accumulation: an input sampled at edge E updates the entry at E. A second add to the same entry at E+1 sees the updated value (back-to-back accumulation without hazard).
- All outputs are registered:
  - The edge that enters DRAIN produces no output.
  - Row (0,0) appears after the next edge.
  - Then one row per edge with ppu_valid = 1.
  - The drain is KC×(boundary+1) contiguous valid cycles.
- ppu_valid and ppu_last are high for exactly one cycle per row; both return to 0 the cycle after the last row.
- ppu_data holds its value when ppu_valid = 0 (don't-care for consumers).

## Test plan
- Reset, then drain with boundary = 3, KC = 2: 8 valid rows (k0 y0..3, k1 y0..3), all data 0, ppu_last only on k1/y3.
- Single-lane accumulate: lane0 (k=1, y=2, x=3, +5) three cycles in a row, then a lane1 add of −2 → drained row k1/y2 has column 3 = 13, all other values 0.
- Same-cycle collision: all 4 lanes target (k0, y0, x0) with 1, 2, 3, 4 → entry 10; a second drain straight after reads all zeros (rows are cleared).
- Range checks: x = 5 with boundary = 3 is dropped; a row drained with boundary = 3 shows columns 4..7 as 0; wrap case 0x7FFF + 1 reads back 0x8000.
- Handshake: drain_en held high for 20 cycles → exactly one drain, then DONE. Lane inputs during DRAIN do not change any entry. drain_en low for one cycle then high → a second drain starts.
- Reset asserted in the middle of a drain → outputs 0 on the next cycle, state ACCUM, and a subsequent drain reads all zeros.

Source files
------------

// File: rtl/pe_accum_buffer.sv
// pe_accum_buffer: per-PE output accumulator. Crossbar lanes add coordinate-tagged
// partial products into a [k][y][x] buffer; on drain request the buffer is streamed
// to the post-processing unit one output row per cycle, clearing each row as it goes.
//
// state   | meaning
// --------+-----------------------------------------------------------------
// S_ACCUM | lanes accumulate into the buffer; waits for drain_en
// S_DRAIN | one row [dk][dy] emitted and cleared per cycle; lanes ignored
// S_DONE  | drain finished; lanes ignored; waits for drain_en to drop
module pe_accum_buffer #(
  parameter int NUM_LANES = 4,
  parameter int KC        = 2,
  parameter int MAX_OUT   = 8,
  parameter int DW        = 16,
  localparam int KW = (KC > 1) ? $clog2(KC) : 1,
  localparam int CW = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [CW-1:0]                  conv_size_output_boundary,
  input  logic                           drain_en,
  input  logic [NUM_LANES-1:0]           xbar_valid,
  input  logic [NUM_LANES*KW-1:0]        xbar_k,
  input  logic [NUM_LANES*CW-1:0]        xbar_x,
  input  logic [NUM_LANES*CW-1:0]        xbar_y,
  input  logic signed [NUM_LANES*DW-1:0] xbar_data,
  output logic                           ppu_valid,
  output logic                           ppu_last,
  output logic [KW-1:0]                  ppu_k,
  output logic [CW-1:0]                  ppu_row,
  output logic signed [MAX_OUT*DW-1:0]   ppu_data
);

  typedef enum logic [1:0] {S_ACCUM, S_DRAIN, S_DONE} state_t;

  state_t state, state_nxt;

  logic [KW-1:0] dk;
  logic [CW-1:0] dy;
  logic [CW-1:0] bnd;
  logic          row_last;

  logic signed [DW-1:0] mem     [KC][MAX_OUT][MAX_OUT];
  logic signed [DW-1:0] mem_nxt [KC][MAX_OUT][MAX_OUT];

  logic [KW-1:0]        lane_k [NUM_LANES];
  logic [CW-1:0]        lane_x [NUM_LANES];
  logic [CW-1:0]        lane_y [NUM_LANES];
  logic signed [DW-1:0] lane_d [NUM_LANES];
  logic                 lane_hit [NUM_LANES];

  assign row_last = (dk == KW'(KC - 1)) && (dy == bnd);

  // Unpack lanes and apply range checks against the live boundary
  always_comb begin
    for (int l = 0; l < NUM_LANES; l++) begin
      lane_k[l]   = xbar_k[l*KW +: KW];
      lane_x[l]   = xbar_x[l*CW +: CW];
      lane_y[l]   = xbar_y[l*CW +: CW];
      lane_d[l]   = xbar_data[l*DW +: DW];
      lane_hit[l] = xbar_valid[l]
                    && (lane_x[l] <= conv_size_output_boundary)
                    && (lane_y[l] <= conv_size_output_boundary)
                    && (int'(lane_k[l]) < KC);
    end
  end

  // Next buffer contents: lanes are folded in one after another so colliding
  // lanes sum together; during a drain the emitted row is zeroed instead
  always_comb begin
    mem_nxt = mem;
    if (state == S_ACCUM) begin
      for (int l = 0; l < NUM_LANES; l++) begin
        if (lane_hit[l]) begin
          mem_nxt[lane_k[l]][lane_y[l]][lane_x[l]] =
            mem_nxt[lane_k[l]][lane_y[l]][lane_x[l]] + lane_d[l];
        end
      end
    end else if (state == S_DRAIN) begin
      for (int c = 0; c < MAX_OUT; c++) begin
        mem_nxt[dk][dy][c] = '0;
      end
    end
  end

  // Buffer storage
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < KC; k++)
        for (int y = 0; y < MAX_OUT; y++)
          for (int x = 0; x < MAX_OUT; x++)
            mem[k][y][x] <= '0;
    end else begin
      mem <= mem_nxt;
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= S_ACCUM;
    else     state <= state_nxt;
  end

  // Next-state decode
  always_comb begin
    state_nxt = state;
    case (state)
      S_ACCUM: if (drain_en) state_nxt = S_DRAIN;
      S_DRAIN: if (row_last) state_nxt = S_DONE;
      S_DONE:  if (!drain_en) state_nxt = S_ACCUM;
      default: state_nxt = S_ACCUM;
    endcase
  end

  // Drain row walker; boundary is frozen when the drain starts
  always_ff @(posedge clk) begin
    if (rst) begin
      dk  <= '0;
      dy  <= '0;
      bnd <= '0;
    end else if (state == S_ACCUM) begin
      if (drain_en) begin
        bnd <= conv_size_output_boundary;
        dk  <= '0;
        dy  <= '0;
      end
    end else if (state == S_DRAIN) begin
      if (dy == bnd) begin
        dy <= '0;
        dk <= dk + KW'(1);
      end else begin
        dy <= dy + CW'(1);
      end
    end
  end

  // Registered PPU outputs; columns past the boundary are forced to zero
  always_ff @(posedge clk) begin
    if (rst) begin
      ppu_valid <= 1'b0;
      ppu_last  <= 1'b0;
      ppu_k     <= '0;
      ppu_row   <= '0;
      ppu_data  <= '0;
    end else begin
      ppu_valid <= 1'b0;
      ppu_last  <= 1'b0;
      if (state == S_DRAIN) begin
        ppu_valid <= 1'b1;
        ppu_last  <= row_last;
        ppu_k     <= dk;
        ppu_row   <= dy;
        for (int c = 0; c < MAX_OUT; c++) begin
          ppu_data[c*DW +: DW] <= (c <= int'(bnd)) ? mem[dk][dy][c] : '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_pe_accum_buffer.sv
// Testbench for pe_accum_buffer: table of single-cycle lane patterns each followed
// by a full drain, plus hand-written sequences for reset, back-to-back adds,
// drain handshake and reset in the middle of a drain.
module tb_pe_accum_buffer;
  localparam int NL = 4;
  localparam int KC = 2;
  localparam int MO = 8;
  localparam int DW = 16;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [2:0]   boundary = '0;
  logic         drain_en = 1'b0;
  logic [3:0]   xbar_valid = '0;
  logic [3:0]   xbar_k = '0;
  logic [11:0]  xbar_x = '0;
  logic [11:0]  xbar_y = '0;
  logic signed [63:0]  xbar_data = '0;
  logic         ppu_valid;
  logic         ppu_last;
  logic [0:0]   ppu_k;
  logic [2:0]   ppu_row;
  logic signed [127:0] ppu_data;

  int n_cmp = 0;
  int n_bad = 0;
  logic [15:0] cap [KC][MO][MO];

  typedef struct packed {
    logic        v;
    logic        k;
    logic [2:0]  y;
    logic [2:0]  x;
    logic [15:0] d;
  } lane_t;

  typedef struct packed {
    lane_t [3:0] ln;
    logic [2:0]  bnd;
    logic        ck;
    logic [2:0]  cy;
    logic [2:0]  cx;
    logic [15:0] ex;
  } vec_t;

  pe_accum_buffer #(.NUM_LANES(NL), .KC(KC), .MAX_OUT(MO), .DW(DW)) dut (
    .clk(clk),
    .rst(rst),
    .conv_size_output_boundary(boundary),
    .drain_en(drain_en),
    .xbar_valid(xbar_valid),
    .xbar_k(xbar_k),
    .xbar_x(xbar_x),
    .xbar_y(xbar_y),
    .xbar_data(xbar_data),
    .ppu_valid(ppu_valid),
    .ppu_last(ppu_last),
    .ppu_k(ppu_k),
    .ppu_row(ppu_row),
    .ppu_data(ppu_data)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic lane_t L(input bit v, input int k, input int y, input int x, input int d);
    lane_t r;
    r.v = v; r.k = 1'(k); r.y = 3'(y); r.x = 3'(x); r.d = 16'(d);
    return r;
  endfunction

  function automatic vec_t mkv(input lane_t l3, input lane_t l2, input lane_t l1, input lane_t l0,
                               input int bnd, input int ck, input int cy, input int cx, input int ex);
    vec_t r;
    r.ln = {l3, l2, l1, l0};
    r.bnd = 3'(bnd); r.ck = 1'(ck); r.cy = 3'(cy); r.cx = 3'(cx); r.ex = 16'(ex);
    return r;
  endfunction

  task automatic chk(input string nm, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", nm, act, act, exp, exp);
    end
  endtask

  // Drive one cycle of lane inputs; starts and ends on a falling edge
  task automatic beat(input lane_t [3:0] ln, input int bnd);
    for (int i = 0; i < 4; i++) begin
      xbar_valid[i]       = ln[i].v;
      xbar_k[i]           = ln[i].k;
      xbar_y[i*3 +: 3]    = ln[i].y;
      xbar_x[i*3 +: 3]    = ln[i].x;
      xbar_data[i*16 +: 16] = ln[i].d;
    end
    boundary = 3'(bnd);
    @(negedge clk);
    xbar_valid = '0;
  endtask

  // drain_en low one cycle, then high; capture 24 cycles of PPU output.
  // drain_en drops at cycle 'hold'; 'noise' drives valid lanes until then.
  task automatic run_drain(input int bnd, input int hold, input bit noise);
    int nrows = 0, first = -1, lastc = -2, order_bad = 0, last_bad = 0;
    for (int k = 0; k < KC; k++)
      for (int y = 0; y < MO; y++)
        for (int x = 0; x < MO; x++)
          cap[k][y][x] = 16'hBEEF;
    xbar_valid = '0;
    drain_en = 1'b0;
    boundary = 3'(bnd);
    @(negedge clk);
    drain_en = 1'b1;
    @(negedge clk);
    for (int cyc = 0; cyc < 24; cyc++) begin
      if (ppu_valid) begin
        if (int'(ppu_k) != nrows / (bnd + 1) || int'(ppu_row) != nrows % (bnd + 1)) order_bad++;
        if (ppu_last != (nrows == 2 * (bnd + 1) - 1)) last_bad++;
        for (int c = 0; c < MO; c++) cap[ppu_k][ppu_row][c] = ppu_data[c*16 +: 16];
        if (first < 0) first = cyc;
        lastc = cyc;
        nrows++;
      end else if (ppu_last) begin
        last_bad++;
      end
      boundary = 3'(~bnd);
      if (cyc == hold) drain_en = 1'b0;
      if (noise && cyc < hold) begin
        xbar_valid = '1; xbar_k = '0; xbar_x = '0; xbar_y = '0;
        xbar_data = {4{16'sd50}};
      end else begin
        xbar_valid = '0;
      end
      @(negedge clk);
    end
    xbar_valid = '0;
    chk("row_count", nrows, 2 * (bnd + 1));
    chk("row_order", order_bad, 0);
    chk("last_flag", last_bad, 0);
    chk("start_latency", first, 1);
    chk("contiguous", lastc - first + 1, nrows);
  endtask

  task automatic check_entries(input int ck, input int cy, input int cx, input int ex, input int bnd);
    int bad = 0;
    for (int k = 0; k < KC; k++)
      for (int y = 0; y <= bnd; y++)
        for (int x = 0; x < MO; x++)
          if (cap[k][y][x] != ((k == ck && y == cy && x == cx) ? 16'(ex) : 16'h0000)) bad++;
    chk("entry_map", bad, 0);
    chk("target", cap[ck][cy][cx], ex & 16'hFFFF);
  endtask

  vec_t tv [8];
  lane_t Z;

  initial begin
    Z = L(0, 0, 0, 0, 0);
    tv[0] = mkv(Z, Z, Z, L(1, 1, 2, 3, 5), 3, 1, 2, 3, 5);
    tv[1] = mkv(L(1, 0, 0, 0, 4), L(1, 0, 0, 0, 3), L(1, 0, 0, 0, 2), L(1, 0, 0, 0, 1), 3, 0, 0, 0, 10);
    tv[2] = mkv(Z, Z, L(1, 0, 1, 1, 7), L(1, 0, 1, 5, 9), 3, 0, 1, 1, 7);
    tv[3] = mkv(Z, L(1, 1, 7, 7, -3), Z, Z, 7, 1, 7, 7, 16'hFFFD);
    tv[4] = mkv(L(1, 0, 3, 2, 1), Z, L(1, 0, 3, 2, 16'h7FFF), Z, 3, 0, 3, 2, 16'h8000);
    tv[5] = mkv(L(0, 0, 0, 1, 99), Z, Z, L(1, 1, 4, 0, 4), 3, 0, 0, 1, 0);
    tv[6] = mkv(Z, Z, Z, L(1, 1, 0, 0, -1), 0, 1, 0, 0, 16'hFFFF);
    tv[7] = mkv(Z, L(1, 0, 5, 5, -100), L(1, 0, 5, 5, 100), Z, 5, 0, 5, 5, 0);

    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("reset_valid", ppu_valid, 0);
    chk("reset_last", ppu_last, 0);
    chk("reset_k", ppu_k, 0);
    chk("reset_row", ppu_row, 0);
    chk("reset_data_nonzero", |ppu_data, 0);

    // Fresh buffer drains as all zeros
    run_drain(3, 1, 0);
    check_entries(0, 0, 0, 0, 3);

    // Back-to-back adds to one entry, then a different lane
    beat({Z, Z, Z, L(1, 1, 2, 3, 5)}, 3);
    beat({Z, Z, Z, L(1, 1, 2, 3, 5)}, 3);
    beat({Z, Z, Z, L(1, 1, 2, 3, 5)}, 3);
    beat({Z, Z, L(1, 1, 2, 3, -2), Z}, 3);
    run_drain(3, 1, 0);
    check_entries(1, 2, 3, 13, 3);
    run_drain(3, 1, 0);
    check_entries(1, 2, 3, 0, 3);

    for (int i = 0; i < 8; i++) begin
      beat(tv[i].ln, int'(tv[i].bnd));
      run_drain(int'(tv[i].bnd), 1, 0);
      check_entries(int'(tv[i].ck), int'(tv[i].cy), int'(tv[i].cx), int'(tv[i].ex), int'(tv[i].bnd));
    end

    // drain_en held high across the whole window with lane traffic: one drain only
    beat({Z, Z, Z, L(1, 0, 2, 2, 11)}, 3);
    run_drain(3, 99, 1);
    check_entries(0, 2, 2, 11, 3);
    // one low cycle re-arms; traffic during DRAIN/DONE must not have landed
    run_drain(3, 20, 0);
    check_entries(0, 0, 0, 0, 3);

    // Reset in the middle of a drain
    beat({Z, Z, Z, L(1, 1, 3, 1, 77)}, 3);
    boundary = 3'd3;
    drain_en = 1'b1;
    @(negedge clk);
    repeat (3) @(negedge clk);
    chk("pre_reset_valid", ppu_valid, 1);
    rst = 1'b1;
    drain_en = 1'b0;
    @(negedge clk);
    chk("midrst_valid", ppu_valid, 0);
    chk("midrst_last", ppu_last, 0);
    chk("midrst_k", ppu_k, 0);
    chk("midrst_row", ppu_row, 0);
    chk("midrst_data_nonzero", |ppu_data, 0);
    rst = 1'b0;
    beat({Z, Z, Z, L(1, 0, 1, 2, 6)}, 3);
    run_drain(3, 1, 0);
    check_entries(0, 1, 2, 6, 3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
